sc_monitor: RTL and testbench

Passive protocol checker sitting on the output side of the saturating counter `sc`. It samples the counter's `out`/`err` each cycle, runs an independent reference model of the 0→5 saturating sequence, and flags any divergence. It drives no counter inputs and sits in the debug/verification-support area next to the counter. Its status outputs feed the error-reporting logic.

---
 rtl/sc_pkg.sv | 24 ++
 rtl/sc_ref_model.sv | 51 +++++
 rtl/sc_monitor.sv | 164 ++++++++++++++++
 tb/tb_sc_monitor.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : sc_pkg                                                         |
// | Purpose : Shared constants and types for the saturating counter `sc`     |
// |           and its passive checker `sc_monitor`.                          |
// | Contents: SC_MAX / SC_CW  - default saturation value and count width     |
// |           mon_state_e     - checker state encoding                       |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package sc_pkg;

  // Defaults shared with the counter so both sides agree on the sequence.
  localparam int SC_MAX = 5;
  localparam int SC_CW  = 3;

  // RESYNC is only reachable when SC_MONITOR_RESYNC_EN is compiled in.
  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    FAULT  = 2'd1,
    RESYNC = 2'd2
  } mon_state_e;

endpackage : sc_pkg
`default_nettype wire

// File: rtl/sc_ref_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sc_ref_model                                                   |
// | Purpose : Golden 0..MAX saturating sequence generator. Holds the count   |
// |           the monitored counter is expected to show this cycle.          |
// | Ports   : clk      in  1   rising-edge clock                             |
// |           rst      in  1   synchronous active-low reset                  |
// |           ctr_rst  in  1   counter reset; expected count is 0 next cycle |
// |           exp_o    out CW  current expected count (registered)           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sc_ref_model
  import sc_pkg::*;
#(
  parameter int MAX = SC_MAX,
  parameter int CW  = SC_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctr_rst,
  output logic [CW-1:0] exp_o
);

  localparam logic [CW-1:0] C_MAX_VAL = CW'(MAX);

  logic [CW-1:0] exp_q;
  logic [CW-1:0] exp_d;

  always_comb begin
    exp_d = exp_q;
    if (ctr_rst) begin
      exp_d = '0;
    end else if (exp_q < C_MAX_VAL) begin
      exp_d = exp_q + 1'b1;
    end else begin
      exp_d = C_MAX_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_o = exp_q;

endmodule : sc_ref_model
`default_nettype wire

// File: rtl/sc_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sc_monitor                                                     |
// | Purpose : Passive checker for the saturating counter `sc`. Compares the  |
// |           counter output against an independent reference sequence and  |
// |           reports divergence, error counts and the first bad value.      |
// | Macro   : SC_MONITOR_RESYNC_EN - adds the RESYNC state, letting FAULT    |
// |           recover after a ctr_rst followed by GOOD_N clean samples.      |
// | Ports   : clk        in  1    rising-edge clock                          |
// |           rst        in  1    synchronous active-low reset               |
// |           ctr_rst    in  1    same reset the counter receives            |
// |           cnt_in     in  CW   counter `out`                              |
// |           cnt_err_in in  1    counter `err`                              |
// |           mismatch   out 1    previous cycle's sample was bad            |
// |           err_sticky out 1    a bad sample has been seen since rst       |
// |           err_count  out ECW  number of bad samples, saturating          |
// |           first_bad  out CW   cnt_in at the first bad sample             |
// |           expected   out CW   reference model's current expected count   |
// |           in_fault   out 1    state is FAULT (or RESYNC)                 |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sc_monitor
  import sc_pkg::*;
#(
  parameter int MAX    = SC_MAX,
  parameter int CW     = SC_CW,
  parameter int ECW    = 8,
  parameter int GOOD_N = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ctr_rst,
  input  logic [CW-1:0]  cnt_in,
  input  logic           cnt_err_in,
  output logic           mismatch,
  output logic           err_sticky,
  output logic [ECW-1:0] err_count,
  output logic [CW-1:0]  first_bad,
  output logic [CW-1:0]  expected,
  output logic           in_fault
);

  localparam logic [CW-1:0] C_MAX_VAL = CW'(MAX);

  logic [CW-1:0]  exp_w;
  logic           bad_w;

  mon_state_e     state_q;
  mon_state_e     state_d;

  logic           mismatch_q;
  logic           err_sticky_q;
  logic [ECW-1:0] err_count_q;
  logic [CW-1:0]  first_bad_q;
  logic           in_fault_q;

  sc_ref_model #(
    .MAX (MAX),
    .CW  (CW)
  ) u_ref_model (
    .clk     (clk),
    .rst     (rst),
    .ctr_rst (ctr_rst),
    .exp_o   (exp_w)
  );

  // The model's current value is compared before it updates, so a ctr_rst
  // only shows up in the comparison one cycle later, like the counter.
  assign bad_w = (cnt_in != exp_w) || (cnt_in > C_MAX_VAL) || cnt_err_in;

`ifdef SC_MONITOR_RESYNC_EN
  localparam int GW = $clog2(GOOD_N + 1);
  localparam logic [GW-1:0] C_GOOD_LAST = GW'(GOOD_N - 1);

  logic [GW-1:0] good_q;
  logic [GW-1:0] good_d;
`else
  logic w_unused_good_n;
  assign w_unused_good_n = (GOOD_N != 0);
`endif

  always_comb begin
    state_d = state_q;
`ifdef SC_MONITOR_RESYNC_EN
    good_d  = good_q;
`endif
    case (state_q)
      TRACK: begin
        if (bad_w) state_d = FAULT;
      end
      FAULT: begin
`ifdef SC_MONITOR_RESYNC_EN
        // ctr_rst wins over a bad sample in the same cycle.
        if (ctr_rst) begin
          state_d = RESYNC;
          good_d  = '0;
        end
`else
        state_d = FAULT;
`endif
      end
`ifdef SC_MONITOR_RESYNC_EN
      RESYNC: begin
        if (bad_w) begin
          state_d = FAULT;
          good_d  = '0;
        end else if (good_q == C_GOOD_LAST) begin
          // This clean sample is the GOOD_N-th one.
          state_d = TRACK;
          good_d  = '0;
        end else begin
          good_d  = good_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = TRACK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= TRACK;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      first_bad_q  <= '0;
      in_fault_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mismatch_q <= bad_w;
      in_fault_q <= (state_d != TRACK);
      if (bad_w) begin
        err_sticky_q <= 1'b1;
        if (err_count_q != {ECW{1'b1}}) begin
          err_count_q <= err_count_q + 1'b1;
        end
        if (!err_sticky_q) begin
          first_bad_q <= cnt_in;
        end
      end
    end
  end

`ifdef SC_MONITOR_RESYNC_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      good_q <= '0;
    end else begin
      good_q <= good_d;
    end
  end
`endif

  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign first_bad  = first_bad_q;
  assign expected   = exp_w;
  assign in_fault   = in_fault_q;

endmodule : sc_monitor
`default_nettype wire

// File: tb/tb_sc_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sc_monitor                                                  |
// | Purpose : Self-checking bench for sc_monitor. A behavioural model of the |
// |           checker's rules predicts every output; directed scenarios and  |
// |           a randomized run are compared against it.                      |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sc_monitor;

  localparam int MAX    = 5;
  localparam int CW     = 3;
  localparam int ECW    = 8;
  localparam int GOOD_N = 2;
  localparam int ECMAX  = (1 << ECW) - 1;

  localparam int M_TRACK  = 0;
  localparam int M_FAULT  = 1;
  localparam int M_RESYNC = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ctr_rst = 1'b0;
  logic [CW-1:0]  cnt_in = '0;
  logic           cnt_err_in = 1'b0;
  logic           mismatch;
  logic           err_sticky;
  logic [ECW-1:0] err_count;
  logic [CW-1:0]  first_bad;
  logic [CW-1:0]  expected;
  logic           in_fault;

  int n_vec = 0;
  int n_mis = 0;

  // Behavioural model state
  int m_exp, m_st, m_good, m_err, m_first;
  bit m_mis, m_sticky;

  always #5 clk = ~clk;

  sc_monitor #(
    .MAX    (MAX),
    .CW     (CW),
    .ECW    (ECW),
    .GOOD_N (GOOD_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctr_rst    (ctr_rst),
    .cnt_in     (cnt_in),
    .cnt_err_in (cnt_err_in),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .first_bad  (first_bad),
    .expected   (expected),
    .in_fault   (in_fault)
  );

  function automatic void model_reset();
    m_exp = 0; m_st = M_TRACK; m_good = 0; m_err = 0;
    m_first = 0; m_mis = 0; m_sticky = 0;
  endfunction

  function automatic void model_step(bit c, int v, bit e);
    bit bad;
    bad = (v != m_exp) || (v > MAX) || e;
    m_mis = bad;
    if (bad) begin
      if (m_err < ECMAX) m_err = m_err + 1;
      if (!m_sticky) m_first = v;
      m_sticky = 1;
    end
    if (m_st == M_TRACK) begin
      if (bad) m_st = M_FAULT;
    end else if (m_st == M_FAULT) begin
`ifdef SC_MONITOR_RESYNC_EN
      if (c) begin m_st = M_RESYNC; m_good = 0; end
`endif
    end else begin
      if (bad) begin
        m_st = M_FAULT; m_good = 0;
      end else begin
        m_good = m_good + 1;
        if (m_good >= GOOD_N) begin m_st = M_TRACK; m_good = 0; end
      end
    end
    m_exp = c ? 0 : ((m_exp < MAX) ? m_exp + 1 : MAX);
  endfunction

  function automatic logic [16:0] model_vec();
    return {m_mis, m_sticky, ECW'(m_err), CW'(m_first), CW'(m_exp), (m_st != M_TRACK)};
  endfunction

  // One clock: drive inputs, let the DUT sample, advance the model, settle.
  task automatic cycle(input bit r, input bit c, input int v, input bit e);
    rst = r; ctr_rst = c; cnt_in = CW'(v); cnt_err_in = e;
    @(posedge clk);
    if (!r) model_reset(); else model_step(c, v, e);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 1, 7, 1);
    cycle(0, 0, 6, 1);
    n_vec++;
    if ({mismatch, err_sticky, err_count, first_bad, expected, in_fault} !== 17'd0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %h, want 0",
               {mismatch, err_sticky, err_count, first_bad, expected, in_fault});
    end
  endtask

  task automatic test_clean_run();
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, (i < 5) ? i : 5, 0);
      n_vec++;
      if (mismatch !== 1'b0) begin
        n_mis++; $display("FAIL clean_mismatch[%0d]: got %b, want 0", i, mismatch);
      end
    end
    n_vec++;
    if (err_count !== ECW'(0)) begin
      n_mis++; $display("FAIL clean_err_count: got %0d, want 0", err_count);
    end
    n_vec++;
    if (expected !== CW'(5)) begin
      n_mis++; $display("FAIL clean_expected: got %0d, want 5", expected);
    end
  endtask

  task automatic test_ctr_rst();
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 2, 0);
    cycle(1, 1, 3, 0);
    n_vec++;
    if (expected !== CW'(0)) begin
      n_mis++; $display("FAIL ctr_rst_expected: got %0d, want 0", expected);
    end
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    n_vec++;
    if ({mismatch, err_count} !== {1'b0, ECW'(0)}) begin
      n_mis++; $display("FAIL ctr_rst_clean: got mismatch=%b err_count=%0d, want 0/0",
                        mismatch, err_count);
    end
    n_vec++;
    if (expected !== CW'(2)) begin
      n_mis++; $display("FAIL ctr_rst_resume: got %0d, want 2", expected);
    end
  endtask

  task automatic test_forced_bad();
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, i, 0);
    cycle(1, 0, 2, 0);
    n_vec++;
    if ({mismatch, err_sticky, in_fault} !== 3'b111) begin
      n_mis++; $display("FAIL forced_flags: got %b%b%b, want 111", mismatch, err_sticky, in_fault);
    end
    n_vec++;
    if (first_bad !== CW'(2)) begin
      n_mis++; $display("FAIL forced_first_bad: got %0d, want 2", first_bad);
    end
    n_vec++;
    if (err_count !== ECW'(1)) begin
      n_mis++; $display("FAIL forced_err_count: got %0d, want 1", err_count);
    end
    cycle(1, 0, 5, 0);
    n_vec++;
    if ({mismatch, in_fault} !== 2'b01) begin
      n_mis++; $display("FAIL forced_hold: got mismatch=%b in_fault=%b, want 0/1", mismatch, in_fault);
    end
  endtask

  task automatic test_back_to_back();
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 6, 0);
      n_vec++;
      if (mismatch !== 1'b1) begin
        n_mis++; $display("FAIL b2b_mismatch[%0d]: got %b, want 1", i, mismatch);
      end
    end
    cycle(1, 0, 4, 1);
    n_vec++;
    if (mismatch !== 1'b1) begin
      n_mis++; $display("FAIL b2b_err_in: got %b, want 1", mismatch);
    end
    n_vec++;
    if ({err_count, first_bad} !== {ECW'(4), CW'(6)}) begin
      n_mis++; $display("FAIL b2b_counts: got err_count=%0d first_bad=%0d, want 4/6",
                        err_count, first_bad);
    end
    cycle(1, 0, 5, 0);
    n_vec++;
    if (mismatch !== 1'b0) begin
      n_mis++; $display("FAIL b2b_end: got %b, want 0", mismatch);
    end
  endtask

  // Runs from the FAULT left by test_back_to_back (model expects 5).
  task automatic test_resync();
    logic want_after;
`ifdef SC_MONITOR_RESYNC_EN
    want_after = 1'b0;
`else
    want_after = 1'b1;
`endif
    cycle(1, 1, 5, 0);
    cycle(1, 0, 0, 0);
    n_vec++;
    if (in_fault !== 1'b1) begin
      n_mis++; $display("FAIL resync_first_clean: got in_fault=%b, want 1", in_fault);
    end
    cycle(1, 0, 1, 0);
    n_vec++;
    if (in_fault !== want_after) begin
      n_mis++; $display("FAIL resync_second_clean: got in_fault=%b, want %b", in_fault, want_after);
    end
    n_vec++;
    if ({err_sticky, err_count} !== {1'b1, ECW'(4)}) begin
      n_mis++; $display("FAIL resync_sticky: got sticky=%b err_count=%0d, want 1/4",
                        err_sticky, err_count);
    end
  endtask

  task automatic test_saturation();
    cycle(0, 0, 0, 0);
    repeat (ECMAX) cycle(1, 0, 7, 0);
    n_vec++;
    if (err_count !== ECW'(ECMAX)) begin
      n_mis++; $display("FAIL sat_reach: got %0d, want %0d", err_count, ECMAX);
    end
    cycle(1, 0, 7, 0);
    n_vec++;
    if ({mismatch, err_count} !== {1'b1, ECW'(ECMAX)}) begin
      n_mis++; $display("FAIL sat_hold: got mismatch=%b err_count=%0d, want 1/%0d",
                        mismatch, err_count, ECMAX);
    end
  endtask

  task automatic test_midreset();
    cycle(0, 0, 0, 0);
    cycle(1, 0, 3, 0);
    cycle(1, 0, 6, 1);
    cycle(0, 1, 7, 1);
    n_vec++;
    if ({mismatch, err_sticky, err_count, first_bad, expected, in_fault} !== 17'd0) begin
      n_mis++; $display("FAIL midreset_outputs: got %h, want 0",
                        {mismatch, err_sticky, err_count, first_bad, expected, in_fault});
    end
    cycle(1, 0, 0, 0);
    n_vec++;
    if ({mismatch, in_fault, expected} !== {1'b0, 1'b0, CW'(1)}) begin
      n_mis++; $display("FAIL midreset_resume: got mismatch=%b in_fault=%b expected=%0d, want 0/0/1",
                        mismatch, in_fault, expected);
    end
  endtask

  task automatic test_random();
    int  v;
    bit  c, e, r;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) >= 2);
      c = ($urandom_range(0, 99) < 12);
      e = ($urandom_range(0, 99) < 4);
      v = ($urandom_range(0, 99) < 85) ? m_exp : int'($urandom_range(0, 7));
      cycle(r, c, v, e);
      n_vec++;
      if ({mismatch, err_sticky, err_count, first_bad, expected, in_fault} !== model_vec()) begin
        n_mis++;
        $display("FAIL random[%0d]: got %h, want %h", i,
                 {mismatch, err_sticky, err_count, first_bad, expected, in_fault}, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_run();
    test_ctr_rst();
    test_forced_bad();
    test_back_to_back();
    test_resync();
    test_saturation();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sc_monitor
`default_nettype wire
